// File: rtl/game_over_overlay.sv
// Two-stage compositor that paints the "GAME OVER" banner over the background, with a frame-locked blink FSM.
// Build option: define GAME_OVER_DIM_EN to darken background pixels inside the banner box while it is visible.
module game_over_overlay #(
  parameter int          ORIGIN_X     = 192,
  parameter int          ORIGIN_Y     = 224,
  parameter int          BANNER_W     = 256,
  parameter int          BANNER_H     = 32,
  parameter int          BLINK_FRAMES = 30,
  parameter int          BLINK_COUNT  = 3,
  parameter logic [15:0] TEXT_COLOR   = 16'hF800
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [15:0] bg_data,
  input  logic        frame_start,
  input  logic        game_over,
  input  logic        restart,
  output logic [7:0]  letter_x,
  output logic [7:0]  letter_y,
  input  logic        letter_bit,
  output logic [15:0] pix_data,
  output logic        overlay_on
);

  localparam int FCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam int HCW     = $clog2(2 * BLINK_COUNT + 1) > 0 ? $clog2(2 * BLINK_COUNT + 1) : 1;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + BANNER_W);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + BANNER_H);
  localparam logic [7:0]  OX8  = 8'(ORIGIN_X);
  localparam logic [7:0]  OY8  = 8'(ORIGIN_Y);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [HCW-1:0] HALF_LAST  = HCW'(2 * BLINK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, BLINK, SHOW} state_t;

  state_t         state_reg, state_next;
  logic           vis_reg, vis_next;
  logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
  logic [HCW-1:0] half_cnt_reg, half_cnt_next;

  logic           in_win;
  logic           in_win_d_reg;
  logic [15:0]    bg_d_reg;
  logic [15:0]    pix_next;
  logic [7:0]     off_x, off_y;

  // 11-bit compares keep ORIGIN+size from wrapping at the 10-bit scan range.
  assign in_win = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                  ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
  assign off_x  = pix_x[7:0] - OX8;
  assign off_y  = pix_y[7:0] - OY8;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      letter_x     <= '0;
      letter_y     <= '0;
      in_win_d_reg <= 1'b0;
      bg_d_reg     <= '0;
      pix_data     <= '0;
    end else begin
      letter_x     <= in_win ? off_x : 8'd0;
      letter_y     <= in_win ? off_y : 8'd0;
      in_win_d_reg <= in_win;
      bg_d_reg     <= bg_data;
      pix_data     <= pix_next;
    end
  end

  always_comb begin
    pix_next = bg_d_reg;
    if (vis_reg && in_win_d_reg) begin
      if (letter_bit) begin
        pix_next = TEXT_COLOR;
      end
`ifdef GAME_OVER_DIM_EN
      else begin
        // Halve each RGB565 field independently.
        pix_next = {1'b0, bg_d_reg[15:12], 1'b0, bg_d_reg[10:6], 1'b0, bg_d_reg[4:1]};
      end
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= IDLE;
      vis_reg       <= 1'b0;
      frame_cnt_reg <= '0;
      half_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      vis_reg       <= vis_next;
      frame_cnt_reg <= frame_cnt_next;
      half_cnt_reg  <= half_cnt_next;
    end
  end

  // vis only moves on frame_start (or restart), so no frame shows a partial banner.
  always_comb begin
    state_next     = state_reg;
    vis_next       = vis_reg;
    frame_cnt_next = frame_cnt_reg;
    half_cnt_next  = half_cnt_reg;
    if (restart) begin
      state_next     = IDLE;
      vis_next       = 1'b0;
      frame_cnt_next = '0;
      half_cnt_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          vis_next = 1'b0;
          if (game_over) state_next = WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            state_next     = BLINK;
            vis_next       = 1'b1;
            frame_cnt_next = '0;
            half_cnt_next  = '0;
          end
        end
        BLINK: begin
          if (frame_start) begin
            if (frame_cnt_reg == FRAME_LAST) begin
              frame_cnt_next = '0;
              half_cnt_next  = half_cnt_reg + 1'b1;
              if (half_cnt_reg == HALF_LAST) begin
                state_next = SHOW;
                vis_next   = 1'b1;
              end else begin
                vis_next = ~vis_reg;
              end
            end else begin
              frame_cnt_next = frame_cnt_reg + 1'b1;
            end
          end
        end
        SHOW: vis_next = 1'b1;
        default: begin
          state_next = IDLE;
          vis_next   = 1'b0;
        end
      endcase
    end
  end

  assign overlay_on = (state_reg != IDLE);

endmodule
